// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the memory-mapped UART transmitter:
//               register offsets (A[3:2]), STATUS bit positions and the
//               transmit FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Register offsets, decoded from A[3:2]
  localparam logic [1:0] ADDR_TXDATA = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_BAUD   = 2'b10;

  // STATUS register bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;

  // Transmit FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_peripheral_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with asynchronous active-high reset.
//               dout shows the head entry combinationally (first-word
//               fall-through). A push while full is accepted only when a
//               pop happens in the same cycle.
// Ports       : clk, rst       - clock, async reset
//               push, din      - write request and data
//               pop, dout      - read request and head data
//               full, empty    - occupancy flags
//               count          - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);
  localparam logic [AW:0]   c_cnt_one = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW + 1)'(DEPTH));
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  assign w_do_pop  = pop && !empty;
  // A slot frees up this cycle if the head is popped, so a full FIFO can
  // still take a push alongside a pop.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_do_push && !w_do_pop)      r_count <= r_count + c_cnt_one;
      else if (w_do_pop && !w_do_push) r_count <= r_count - c_cnt_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_peripheral
// Description : Memory-mapped 8N1 UART transmitter. The core pushes bytes
//               into a TX FIFO; a baud-rate FSM shifts them out LSB first.
// Ports       : clk, rst  - clock, async active-high reset
//               A          - byte address, A[3:2] selects the register
//               WD, WE     - write data and write strobe
//               RD         - combinational read data
//               tx         - serial output, idles high
//               irq        - FIFO empty and transmitter idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_peripheral
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    w_sel;
  logic          w_wr_tx;
  logic          w_wr_stat;
  logic          w_wr_baud;
  logic          w_ovf_set;
  logic [15:0]   r_baud;
  logic          r_ovf;

  logic          w_pop;
  logic [7:0]    w_dout;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  tx_state_e     r_state, w_state_nxt;
  logic [15:0]   r_cnt, w_cnt_nxt;
  logic [15:0]   r_period, w_period_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic          r_tx, w_tx_nxt;
  logic          w_bit_done;
  logic          w_unused;

  assign w_sel     = A[3:2];
  assign w_wr_tx   = WE && (w_sel == ADDR_TXDATA);
  assign w_wr_stat = WE && (w_sel == ADDR_STATUS);
  assign w_wr_baud = WE && (w_sel == ADDR_BAUD);
  assign w_ovf_set = w_wr_tx && w_full && !w_pop;
  assign w_unused  = ^{A[1:0], WD[31:16]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_wr_tx),
    .pop   (w_pop),
    .din   (WD[7:0]),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Register file: BAUD_DIV and the sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_baud <= DEFAULT_DIV;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr_baud) r_baud <= WD[15:0];
      if (w_ovf_set)                r_ovf <= 1'b1;
      else if (w_wr_stat && WD[3])  r_ovf <= 1'b0;
    end
  end

  always_comb begin
    RD = '0;
    case (w_sel)
      ADDR_STATUS: begin
        RD[STAT_BUSY]                 = (r_state != IDLE);
        RD[STAT_FULL]                 = w_full;
        RD[STAT_EMPTY]                = w_empty;
        RD[STAT_OVF]                  = r_ovf;
        RD[STAT_CNT_LSB +: CW]        = w_count;
      end
      ADDR_BAUD:   RD[15:0] = r_baud;
      default:     RD = '0;
    endcase
  end

  // r_period holds the divider latched at frame start, so BAUD_DIV writes
  // mid-frame only affect the next frame.
  assign w_bit_done = (r_cnt == r_period);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period;
    w_shift_nxt  = r_shift;
    w_idx_nxt    = r_idx;
    w_tx_nxt     = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_nxt  = w_dout;
          w_period_nxt = r_baud;
          w_cnt_nxt    = '0;
          w_tx_nxt     = 1'b0;
          w_state_nxt  = START;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = DATA;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
          end else begin
            // tx is registered, so it takes the bit that becomes shift[0]
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_idx_nxt   = r_idx + 3'd1;
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      STOP: begin
        if (w_bit_done) begin
          w_cnt_nxt = '0;
          if (!w_empty) begin
            // Chain straight into the next start bit with no idle gap
            w_pop        = 1'b1;
            w_shift_nxt  = w_dout;
            w_period_nxt = r_baud;
            w_tx_nxt     = 1'b0;
            w_state_nxt  = START;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_period <= '0;
      r_shift  <= '0;
      r_idx    <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_period <= w_period_nxt;
      r_shift  <= w_shift_nxt;
      r_idx    <= w_idx_nxt;
      r_tx     <= w_tx_nxt;
    end
  end

  assign tx  = r_tx;
  assign irq = w_empty && (r_state == IDLE);

endmodule
`default_nettype wire
